sipo_loader: RTL and testbench
==============================

SIPO_LOADER -- requirements
Module: sipo_loader

Interface
REQ-001 Parameter: n, default 4, data word width in bits; the legal range SHALL be n >= 2.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset, synchronous and active-high, sampled on rising clk.
REQ-004 Port: start  input  1  frame-start request, sampled only in IDLE.
REQ-005 Port: sin  input  1  serial data bit, MSB first.
REQ-006 Port: sin_valid  input  1  qualifies sin; a bit SHALL be accepted only on an edge where sin_valid=1.
REQ-007 Port: dout  output  n  last completed word, registered; drives the downstream n-bit register input.
REQ-008 Port: dout_valid  output  1  one-cycle pulse marking a new word on dout.
REQ-009 Port: busy  output  1  high while a frame is in progress (state not IDLE).
REQ-010 Port: parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when the parity feature is compiled out.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and PARITY, with PARITY present only when the parity feature is compiled in.
REQ-012 IDLE -> SHIFT on an edge with start=1; the shift register and bit counter SHALL clear on that edge, and sin is not captured on that edge even if sin_valid=1.
REQ-013 In SHIFT, each accepted bit SHALL shift in at the LSB (shreg <= {shreg[n-2:0], sin}) and increment the counter; the counter width is clog2(n+1).
REQ-014 A cycle with sin_valid=0 SHALL leave the shift register, counter and state unchanged (stall of any length).
REQ-015 Parity feature compiled out: on the edge accepting the n-th bit, dout SHALL load the assembled word, dout_valid SHALL pulse high for exactly the following cycle, and the FSM SHALL return to IDLE on that same edge.
REQ-016 Because of REQ-015, busy SHALL fall on the same edge that dout_valid rises.
REQ-017 start asserted while busy=1 SHALL be ignored and SHALL NOT restart the frame.
REQ-018 dout SHALL hold its value between completed words and SHALL NOT change during shifting.
REQ-019 dout_valid and parity_err SHALL never be high in the same cycle.
REQ-020 A new frame may start on the cycle immediately after a completed frame (back-to-back operation, no gap required).

Reset
REQ-021 rst=1 SHALL force state IDLE and set dout=0, dout_valid=0, busy=0, parity_err=0, shift register=0 and counter=0.
REQ-022 rst SHALL take priority over start and sin_valid on the same edge.
REQ-023 A reset mid-frame SHALL discard the partial word with no dout_valid pulse.

Configuration
REQ-024 Macro SIPO_PARITY_CHECK_EN, when defined, SHALL add an even-parity bit after the n data bits.
REQ-025 With SIPO_PARITY_CHECK_EN defined, the n-th data bit SHALL move the FSM SHIFT -> PARITY, and the next accepted bit is the parity bit.
REQ-026 With SIPO_PARITY_CHECK_EN defined, on the parity-accept edge: if XOR(word, pbit)=0, dout loads and dout_valid pulses; otherwise dout is unchanged and parity_err pulses; in both cases the FSM returns to IDLE.
REQ-027 With SIPO_PARITY_CHECK_EN undefined, there SHALL be no PARITY state and parity_err SHALL be tied to 0; port list and timing are otherwise identical.

Verification
REQ-028 n=4, no parity: start, then bits 1,0,1,1 on consecutive cycles -> dout=4'b1011 and dout_valid high for exactly 1 cycle; busy low in that same cycle.
REQ-029 n=4: same bits with sin_valid=0 for 3 cycles between bit 2 and bit 3 -> dout=4'b1011; dout_valid delayed by exactly 3 cycles.
REQ-030 n=10: two back-to-back frames 10'b1000100010 then 10'b1010100010 -> two dout_valid pulses with matching dout values; a start asserted mid-frame is ignored.
REQ-031 n=4: rst after 2 bits, then a new frame 0,1,1,0 -> no pulse for the aborted frame; dout=0 until 4'b0110 loads.
REQ-032 SIPO_PARITY_CHECK_EN defined, n=4: bits 1,0,1,1 with parity 1 -> dout=4'b1011 and dout_valid; the same word with parity 0 -> parity_err pulse and dout keeps its prior value.
REQ-033 start and sin_valid=1 on the same IDLE cycle -> that bit is not captured; the word is formed from the next 4 accepted bits only.

Source files
------------

// File: rtl/sipo_loader.sv
// rtl/sipo_loader.sv - serial-in parallel-out word loader, MSB first, qualified by sin_valid.
// Optional even-parity check after the data bits is compiled in with SIPO_PARITY_CHECK_EN.
module sipo_loader #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sin,
  input  logic         sin_valid,
  output logic [n-1:0] dout,
  output logic         dout_valid,
  output logic         busy,
  output logic         parity_err
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

`ifdef SIPO_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t          state_q, state_d;
  logic [n-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [n-1:0]    dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic [n-1:0]    shifted;
`ifdef SIPO_PARITY_CHECK_EN
  logic            parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif
    shifted      = (shreg_q << 1) | {{(n-1){1'b0}}, sin};
    case (state_q)
      IDLE: begin
        // sin is deliberately not sampled on the start edge
        if (start) begin
          state_d = SHIFT;
          shreg_d = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
`ifdef SIPO_PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d      = IDLE;
            dout_d       = shifted;
            dout_valid_d = 1'b1;
`endif
          end
        end
      end
`ifdef SIPO_PARITY_CHECK_EN
      PARITY: begin
        if (sin_valid) begin
          state_d = IDLE;
          if (^{shreg_q, sin} == 1'b0) begin
            dout_d       = shreg_q;
            dout_valid_d = 1'b1;
          end else begin
            parity_err_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);
`ifdef SIPO_PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_loader.sv
// tb/tb_sipo_loader.sv - bench for sipo_loader at n=4 and n=10 against a bit-queue reference model.
module tb_sipo_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sin, sin_valid;
  logic [3:0] dout_a;
  logic       dv_a, busy_a, pe_a;
  logic [9:0] dout_b;
  logic       dv_b, busy_b, pe_b;

`ifdef SIPO_PARITY_CHECK_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  sipo_loader #(.n(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
    .dout(dout_a), .dout_valid(dv_a), .busy(busy_a), .parity_err(pe_a)
  );

  sipo_loader #(.n(10)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
    .dout(dout_b), .dout_valid(dv_b), .busy(busy_b), .parity_err(pe_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int  width [2] = '{4, 10};
  bit  m_busy[2];
  int  m_cnt [2];
  int  m_word[2];
  int  m_dout[2];
  bit  m_dv  [2];
  bit  m_pe  [2];

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: a frame is a list of accepted bits; it completes once width (+parity) bits are in.
  task automatic model_step();
    for (int l = 0; l < 2; l++) begin
      m_dv[l] = 1'b0;
      m_pe[l] = 1'b0;
      if (rst) begin
        m_busy[l] = 1'b0;
        m_dout[l] = 0;
        m_cnt[l]  = 0;
        m_word[l] = 0;
      end else if (!m_busy[l]) begin
        if (start) begin
          m_busy[l] = 1'b1;
          m_cnt[l]  = 0;
          m_word[l] = 0;
        end
      end else if (sin_valid) begin
        m_word[l] = m_word[l] * 2 + int'(sin);
        m_cnt[l]++;
        if (m_cnt[l] == width[l] + PB) begin
          m_busy[l] = 1'b0;
          if (PB == 0) begin
            m_dout[l] = m_word[l];
            m_dv[l]   = 1'b1;
          end else if ($countones(m_word[l]) % 2 == 0) begin
            m_dout[l] = m_word[l] / 2;
            m_dv[l]   = 1'b1;
          end else begin
            m_pe[l] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a_dout",  int'(dout_a), m_dout[0]);
    check("a_valid", int'(dv_a),   int'(m_dv[0]));
    check("a_busy",  int'(busy_a), int'(m_busy[0]));
    check("a_perr",  int'(pe_a),   int'(m_pe[0]));
    check("b_dout",  int'(dout_b), m_dout[1]);
    check("b_valid", int'(dv_b),   int'(m_dv[1]));
    check("b_busy",  int'(busy_b), int'(m_busy[1]));
    check("b_perr",  int'(pe_b),   int'(m_pe[1]));
  endtask

  task automatic cycle(input logic st, input logic sv, input logic s, input logic r);
    start     = st;
    sin_valid = sv;
    sin       = s;
    rst       = r;
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  // Sends len bits MSB first; start is also raised on bit index start_at to prove it is ignored.
  task automatic send_word(input logic [15:0] w, input int len, input int start_at);
    for (int k = 0; k < len; k++)
      cycle(k == start_at, 1'b1, w[len-1-k], 1'b0);
    if (PB == 1)
      cycle(1'b0, 1'b1, ^w, 1'b0);
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      m_busy[l] = 0; m_cnt[l] = 0; m_word[l] = 0; m_dout[l] = 0; m_dv[l] = 0; m_pe[l] = 0;
    end
    start = 0; sin = 0; sin_valid = 0; rst = 1;

    cycle(0, 0, 0, 1);
    cycle(1, 1, 1, 1);
    check("reset_dout", int'(dout_a), 0);
    check("reset_busy", int'(busy_a), 0);

    cycle(1, 0, 0, 0);
    send_word(16'b1011, 4, -1);
    check("basic_dout",  int'(dout_a), 4'b1011);
    check("basic_valid", int'(dv_a), 1);
    check("basic_busy",  int'(busy_a), 0);
    cycle(0, 0, 0, 0);
    check("basic_pulse_len", int'(dv_a), 0);

    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    repeat (3) cycle(0, 0, 1'($urandom), 0);
    check("stall_hold_busy", int'(busy_a), 1);
    cycle(0, 1, 1, 0);
    check("stall_early", int'(dv_a), 0);
    cycle(0, 1, 1, 0);
    if (PB == 1) cycle(0, 1, 1, 0);
    check("stall_dout",  int'(dout_a), 4'b1011);
    check("stall_valid", int'(dv_a), 1);

    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    send_word(16'b1000100010, 10, 5);
    check("b2b_w1", int'(dout_b), 10'b1000100010);
    check("b2b_v1", int'(dv_b), 1);
    cycle(1, 0, 0, 0);
    send_word(16'b1010100010, 10, -1);
    check("b2b_w2", int'(dout_b), 10'b1010100010);
    check("b2b_v2", int'(dv_b), 1);

    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    check("abort_dout", int'(dout_a), 0);
    check("abort_busy", int'(busy_a), 0);
    cycle(1, 0, 0, 0);
    send_word(16'b0110, 4, -1);
    check("abort_new_dout", int'(dout_a), 4'b0110);

    cycle(0, 0, 0, 1);
    cycle(1, 1, 1, 0);
    send_word(16'b0110, 4, -1);
    check("start_bit_skip", int'(dout_a), 4'b0110);
    check("start_bit_vld",  int'(dv_a), 1);

`ifdef SIPO_PARITY_CHECK_EN
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    check("par_bad_err",  int'(pe_a), 1);
    check("par_bad_vld",  int'(dv_a), 0);
    check("par_bad_dout", int'(dout_a), 4'b0110);
    cycle(1, 0, 0, 0);
    send_word(16'b1011, 4, -1);
    check("par_ok_dout", int'(dout_a), 4'b1011);
    check("par_ok_err",  int'(pe_a), 0);
`endif

    cycle(0, 0, 0, 1);
    repeat (3000)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
            $urandom_range(0, 99) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
